// File: rtl/seq_detect_pkg.sv
// Shared elaboration-time helpers for the Mealy serial pattern detector.
// Nothing in here becomes runtime logic; it only shapes constants and widths.
package seq_detect_pkg;

  // Width of a state register able to hold 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic pat_bit(input logic [15:0] pattern, input int idx);
    logic [15:0] sh;
    sh = pattern >> idx;
    return sh[0];
  endfunction

  // Next state after k matched bits followed by bit b: the longest pattern
  // prefix (shorter than the full pattern) that ends the string seen so far.
  // A full match therefore lands on the pattern's own failure length.
  function automatic int fail_len(input logic [15:0] pattern, input int width,
                                  input int k, input logic b);
    int   n;
    int   best;
    logic ok;
    logic sb;
    n    = k + 1;
    best = 0;
    for (int len = 1; len < width; len++) begin
      if (len <= n) begin
        ok = 1'b1;
        for (int i = 0; i < len; i++) begin
          sb = ((n - len + i) == k) ? b : pat_bit(pattern, width - 1 - (n - len + i));
          if (sb != pat_bit(pattern, width - 1 - i)) ok = 1'b0;
        end
        if (ok) best = len;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_detect_mealy.sv
// Parametrised Mealy detector for a PAT_W-bit pattern received MSB first,
// with optional overlapping matches and a saturating match counter.
//
// state | meaning
// k     | the k leading pattern bits have been matched (0..PAT_W-1)
// other | unreachable; treated as 0 if ever entered
module seq_detect_mealy
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8,
  localparam int              ST_W    = clog2_min1(PAT_W)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             din_vld,
  input  logic             din,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic [ST_W-1:0]  c_state,
  output logic [ST_W-1:0]  n_state
);

  // Transition table indexed by {state, bit}, fully resolved at elaboration.
  logic [ST_W-1:0] nxt_tbl [2*PAT_W];

  for (genvar k = 0; k < PAT_W; k++) begin : g_k
    for (genvar b = 0; b < 2; b++) begin : g_b
      localparam bit IS_MATCH = (k == PAT_W - 1) && (b == int'(PATTERN[0]));
      localparam int NXT = (IS_MATCH && !OVERLAP) ? 0
                         : fail_len(16'(PATTERN), PAT_W, k, 1'(b));
      assign nxt_tbl[2*k + b] = ST_W'(NXT);
    end
  end

  always_comb begin
    n_state = c_state;
    dout    = 1'b0;
    if (clr) begin
      n_state = '0;
    end else if (din_vld) begin
      if (int'(c_state) < PAT_W) begin
        n_state = nxt_tbl[{c_state, din}];
        dout    = (int'(c_state) == PAT_W - 1) && (din == PATTERN[0]);
      end else begin
        n_state = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      c_state   <= '0;
      match_cnt <= '0;
    end else begin
      c_state <= n_state;
      if (clr) begin
        match_cnt <= '0;
      end else if (dout && (match_cnt != '1)) begin
        match_cnt <= match_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Bench for seq_detect_mealy: four configurations share one input stream and
// are checked every cycle against a stream-history model plus directed literals.
module tb_seq_detect_mealy;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic clr = 1'b0;
  logic din_vld = 1'b0;
  logic din = 1'b0;

  always #5 clk = ~clk;

  logic       dout_ov, dout_no, dout_sat, dout_sw;
  logic [7:0] cnt_ov, cnt_no, cnt_sw;
  logic [1:0] cnt_sat;
  logic [1:0] cs_ov, ns_ov, cs_no, ns_no;
  logic       cs_sat, ns_sat;
  logic [2:0] cs_sw, ns_sw;

  seq_detect_mealy #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .n_rst(n_rst), .clr(clr), .din_vld(din_vld), .din(din),
    .dout(dout_ov), .match_cnt(cnt_ov), .c_state(cs_ov), .n_state(ns_ov));

  seq_detect_mealy #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
    .clk(clk), .n_rst(n_rst), .clr(clr), .din_vld(din_vld), .din(din),
    .dout(dout_no), .match_cnt(cnt_no), .c_state(cs_no), .n_state(ns_no));

  seq_detect_mealy #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .n_rst(n_rst), .clr(clr), .din_vld(din_vld), .din(din),
    .dout(dout_sat), .match_cnt(cnt_sat), .c_state(cs_sat), .n_state(ns_sat));

  seq_detect_mealy #(.PAT_W(8), .PATTERN(8'b10101010), .OVERLAP(1'b1), .CNT_W(8)) u_sw (
    .clk(clk), .n_rst(n_rst), .clr(clr), .din_vld(din_vld), .din(din),
    .dout(dout_sw), .match_cnt(cnt_sw), .c_state(cs_sw), .n_state(ns_sw));

  int act_dout [4];
  int act_cs   [4];
  int act_ns   [4];
  int act_cnt  [4];

  always_comb begin
    act_dout[0] = int'(dout_ov);  act_cs[0] = int'(cs_ov);  act_ns[0] = int'(ns_ov);  act_cnt[0] = int'(cnt_ov);
    act_dout[1] = int'(dout_no);  act_cs[1] = int'(cs_no);  act_ns[1] = int'(ns_no);  act_cnt[1] = int'(cnt_no);
    act_dout[2] = int'(dout_sat); act_cs[2] = int'(cs_sat); act_ns[2] = int'(ns_sat); act_cnt[2] = int'(cnt_sat);
    act_dout[3] = int'(dout_sw);  act_cs[3] = int'(cs_sw);  act_ns[3] = int'(ns_sw);  act_cnt[3] = int'(cnt_sw);
  end

  localparam logic [15:0] PATS [4] = '{16'h000B, 16'h000B, 16'h0003, 16'h00AA};
  localparam int          WS   [4] = '{4, 4, 2, 8};
  localparam bit          OVS  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam int          CMAX [4] = '{255, 255, 3, 255};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: remember the valid bits since the last restart (newest in bit 0).
  // The state is the longest pattern prefix, shorter than the pattern, that
  // ends that history; a match is the whole pattern ending it.
  logic [15:0] hist [4];
  int          hlen [4];
  int          mcnt [4];

  function automatic int sfx_pfx(input logic [15:0] pat, input int w,
                                 input logic [15:0] h, input int len);
    bit ok;
    for (int l = w - 1; l >= 1; l--) begin
      if (l <= len) begin
        ok = 1'b1;
        for (int j = 0; j < l; j++)
          if (h[j] != pat[w-l+j]) ok = 1'b0;
        if (ok) return l;
      end
    end
    return 0;
  endfunction

  function automatic bit full_match(input logic [15:0] pat, input int w,
                                    input logic [15:0] h, input int len);
    if (len < w) return 1'b0;
    for (int j = 0; j < w; j++)
      if (h[j] != pat[j]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 4; i++) begin
        hist[i] = '0; hlen[i] = 0; mcnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin : upd
        logic [15:0] nh;
        int          nl;
        if (clr) begin
          hist[i] = '0; hlen[i] = 0; mcnt[i] = 0;
        end else if (din_vld) begin
          nh = {hist[i][14:0], din};
          nl = (hlen[i] < 16) ? hlen[i] + 1 : 16;
          if (full_match(PATS[i], WS[i], nh, nl)) begin
            if (mcnt[i] < CMAX[i]) mcnt[i]++;
            if (!OVS[i]) begin
              nh = '0; nl = 0;
            end
          end
          hist[i] = nh; hlen[i] = nl;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin : cmp
      logic [15:0] nh;
      int          nl;
      int          e_cs, e_ns, e_dout;
      e_cs   = sfx_pfx(PATS[i], WS[i], hist[i], hlen[i]);
      e_ns   = e_cs;
      e_dout = 0;
      if (clr) begin
        e_ns = 0;
      end else if (din_vld) begin
        nh = {hist[i][14:0], din};
        nl = (hlen[i] < 16) ? hlen[i] + 1 : 16;
        e_dout = int'(full_match(PATS[i], WS[i], nh, nl));
        if (e_dout != 0 && !OVS[i]) e_ns = 0;
        else e_ns = sfx_pfx(PATS[i], WS[i], nh, nl);
      end
      check($sformatf("model dout[%0d]", i), act_dout[i], e_dout);
      check($sformatf("model c_state[%0d]", i), act_cs[i], e_cs);
      check($sformatf("model n_state[%0d]", i), act_ns[i], e_ns);
      check($sformatf("model match_cnt[%0d]", i), act_cnt[i], mcnt[i]);
    end
  end

  int last_dout [4];
  int last_ns_ov;

  // Apply one cycle of inputs; capture the Mealy outputs mid-cycle, then step past the edge.
  task automatic step(input logic v, input logic d, input logic c);
    din_vld = v; din = d; clr = c;
    @(negedge clk);
    for (int i = 0; i < 4; i++) last_dout[i] = act_dout[i];
    last_ns_ov = act_ns[0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [0:6]  s7;
    logic [0:6]  e_ov;
    logic [0:6]  e_no;
    int          no_cs [7];

    // Reset mid-pattern
    #22 n_rst = 1'b1;
    @(posedge clk); #1;
    check("reset c_state", act_cs[0], 0);
    check("reset match_cnt", act_cnt[0], 0);
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
    check("pre-reset c_state", act_cs[0], 3);
    #2 n_rst = 1'b0; din_vld = 1'b0; din = 1'b1;
    #1;
    check("async reset c_state", act_cs[0], 0);
    check("async reset match_cnt", act_cnt[0], 0);
    check("async reset dout", act_dout[0], 0);
    #3 n_rst = 1'b1;
    @(posedge clk); #1;

    // Overlap vs non-overlap on 1,0,1,1,0,1,1
    s7    = 7'b1011011;
    e_ov  = 7'b0001001;
    e_no  = 7'b0001000;
    no_cs = '{1, 2, 3, 0, 0, 1, 1};
    step(0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      step(1, s7[i], 0);
      check($sformatf("ovl dout bit%0d", i + 1), last_dout[0], int'(e_ov[i]));
      check($sformatf("novl dout bit%0d", i + 1), last_dout[1], int'(e_no[i]));
      check($sformatf("novl c_state bit%0d", i + 1), act_cs[1], no_cs[i]);
      if (i == 3) check("ovl c_state after match", act_cs[0], 1);
    end
    check("ovl match_cnt", act_cnt[0], 2);
    check("novl match_cnt", act_cnt[1], 1);

    // Valid gating, then clear at state 3
    step(0, 0, 1);
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
    check("gap pre c_state", act_cs[0], 3);
    step(0, 0, 0);
    check("gap hold c_state", act_cs[0], 3);
    check("gap dout", last_dout[0], 0);
    step(1, 1, 0);
    check("post-gap dout", last_dout[0], 1);
    check("post-gap match_cnt", act_cnt[0], 1);
    step(1, 0, 0); step(1, 1, 0);
    check("pre-clr c_state", act_cs[0], 3);
    step(1, 1, 1);
    check("clr dout", last_dout[0], 0);
    check("clr n_state", last_ns_ov, 0);
    check("clr c_state", act_cs[0], 0);
    check("clr match_cnt", act_cnt[0], 0);

    // Saturation with a 2-bit counter
    step(0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0);
      check($sformatf("sat dout bit%0d", i + 1), last_dout[2], (i >= 1) ? 1 : 0);
      check($sformatf("sat match_cnt bit%0d", i + 1), act_cnt[2], (i < 3) ? i : 3);
    end

    // 8-bit alternating pattern
    step(0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      step(1, (i % 2 == 0) ? 1'b1 : 1'b0, 0);
      check($sformatf("sweep dout bit%0d", i + 1), last_dout[3],
            (i >= 7 && (i % 2 == 1)) ? 1 : 0);
    end
    check("sweep match_cnt", act_cnt[3], 5);

    step(0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
